// File: rtl/z_buffer_core.sv
// z_buffer_core
//   Depth-test stage fed by the contention tree. Each accepted pixel is split
//   into {address, depth}. The stored depth is read, and the new depth is
//   written back only when it is strictly closer (smaller, unsigned).
//   A separate synchronous read port lets the display side scan the buffer.
//
// Optional feature macro: Z_BUFFER_STATS_EN
//   When defined, the block adds saturating pass/reject counters
//   (cnt_pass, cnt_reject). They are zeroed at reset and at the start of
//   every clear sweep.
//
// Ports
//   clk            clock
//   reset          synchronous, active-high
//   pix_in         {addr, depth} pixel word
//   send_z_buffer  pix_in valid
//   rdy_z_buffer   core accepts a pixel (decoded from state)
//   clear          request a full buffer reinitialisation
//   busy_clear     clear sweep in progress (decoded from state)
//   upd_valid      one-cycle pulse after a depth write
//   upd_addr       address of the last depth write
//   upd_depth      depth of the last depth write
//   disp_addr      display read address
//   disp_depth     stored depth at disp_addr, one cycle later (read-before-write)
//   cnt_pass       [stats only] pixels that passed the depth test
//   cnt_reject     [stats only] pixels that failed the depth test
//
// FSM states
//   state | meaning
//   CLEAR | write all-ones to every address, one per cycle
//   IDLE  | wait for a pixel; a pending clear wins
//   READ  | read the stored depth at the latched address
//   CMP   | compare, write back on pass, report the update
module z_buffer_core #(
  parameter int PIXEL_WIDTH = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PIXEL_WIDTH-1:0] pix_in,
  input  logic                   send_z_buffer,
  output logic                   rdy_z_buffer,
  input  logic                   clear,
  output logic                   busy_clear,
  output logic                   upd_valid,
  output logic [ADDR_WIDTH-1:0]  upd_addr,
  output logic [DEPTH_WIDTH-1:0] upd_depth,
  input  logic [ADDR_WIDTH-1:0]  disp_addr,
  output logic [DEPTH_WIDTH-1:0] disp_depth
`ifdef Z_BUFFER_STATS_EN
  ,
  output logic [15:0]            cnt_pass,
  output logic [15:0]            cnt_reject
`endif
);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_CMP   = 2'd3;

  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR  = '1;
  localparam logic [DEPTH_WIDTH-1:0] DEPTH_ONES = '1;
  localparam int                     MEM_DEPTH  = 1 << ADDR_WIDTH;

  logic [1:0]             r_state;
  logic [ADDR_WIDTH-1:0]  r_clr_cnt;
  logic                   r_clr_pend;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DEPTH_WIDTH-1:0] r_depth;
  logic [DEPTH_WIDTH-1:0] r_rd_data;
  logic [DEPTH_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                   w_pass;
  logic                   w_we;
  logic [ADDR_WIDTH-1:0]  w_waddr;
  logic [DEPTH_WIDTH-1:0] w_wdata;

  assign rdy_z_buffer = (r_state == S_IDLE) && !r_clr_pend;
  assign busy_clear   = (r_state == S_CLEAR);
  // All-ones depth can never pass against a cleared location.
  assign w_pass       = (r_depth < r_rd_data);

  // Single write port shared by the clear sweep and the depth update.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_clr_cnt;
    w_wdata = DEPTH_ONES;
    if (!reset) begin
      if (r_state == S_CLEAR) begin
        w_we = 1'b1;
      end else if (r_state == S_CMP && w_pass) begin
        w_we    = 1'b1;
        w_waddr = r_addr;
        w_wdata = r_depth;
      end
    end
  end

  // Storage is not reset; the sweep that follows every reset initialises it.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_CLEAR;
      r_clr_cnt  <= '0;
      r_clr_pend <= 1'b0;
      r_addr     <= '0;
      r_depth    <= '0;
      r_rd_data  <= '0;
      upd_valid  <= 1'b0;
      upd_addr   <= '0;
      upd_depth  <= '0;
      disp_depth <= '0;
`ifdef Z_BUFFER_STATS_EN
      cnt_pass   <= '0;
      cnt_reject <= '0;
`endif
    end else begin
      upd_valid  <= 1'b0;
      // Nonblocking read of the array returns the pre-write value.
      disp_depth <= r_mem[disp_addr];
      case (r_state)
        S_CLEAR: begin
          // Requests arriving during a sweep are absorbed.
          r_clr_pend <= 1'b0;
          r_clr_cnt  <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == LAST_ADDR) begin
            r_state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (r_clr_pend) begin
            r_state    <= S_CLEAR;
            r_clr_cnt  <= '0;
            r_clr_pend <= 1'b0;
`ifdef Z_BUFFER_STATS_EN
            cnt_pass   <= '0;
            cnt_reject <= '0;
`endif
          end else begin
            r_clr_pend <= clear;
            if (send_z_buffer) begin
              r_addr  <= pix_in[PIXEL_WIDTH-1 -: ADDR_WIDTH];
              r_depth <= pix_in[DEPTH_WIDTH-1:0];
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          r_clr_pend <= r_clr_pend | clear;
          r_rd_data  <= r_mem[r_addr];
          r_state    <= S_CMP;
        end
        S_CMP: begin
          r_clr_pend <= r_clr_pend | clear;
          if (w_pass) begin
            upd_valid <= 1'b1;
            upd_addr  <= r_addr;
            upd_depth <= r_depth;
`ifdef Z_BUFFER_STATS_EN
            if (cnt_pass != 16'hFFFF) cnt_pass <= cnt_pass + 16'd1;
          end else begin
            if (cnt_reject != 16'hFFFF) cnt_reject <= cnt_reject + 16'd1;
`endif
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_CLEAR;
          r_clr_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z_buffer_core.sv
module tb_z_buffer_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pix_in;
  logic        send_z_buffer;
  logic        rdy_z_buffer;
  logic        clear;
  logic        busy_clear;
  logic        upd_valid;
  logic [7:0]  upd_addr;
  logic [7:0]  upd_depth;
  logic [7:0]  disp_addr;
  logic [7:0]  disp_depth;
`ifdef Z_BUFFER_STATS_EN
  logic [15:0] cnt_pass;
  logic [15:0] cnt_reject;
`endif

  int n_vec = 0;
  int n_err = 0;

  z_buffer_core dut (
    .clk(clk), .reset(reset), .pix_in(pix_in), .send_z_buffer(send_z_buffer),
    .rdy_z_buffer(rdy_z_buffer), .clear(clear), .busy_clear(busy_clear),
    .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_depth(upd_depth),
    .disp_addr(disp_addr), .disp_depth(disp_depth)
`ifdef Z_BUFFER_STATS_EN
    , .cnt_pass(cnt_pass), .cnt_reject(cnt_reject)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input string name);
    int n;
    n = 0;
    while (!rdy_z_buffer && n < 400) begin
      tick();
      n++;
    end
    n_vec++;
    if (rdy_z_buffer !== 1'b1) begin
      n_err++;
      $display("FAIL %s: rdy timeout, got %b want 1", name, rdy_z_buffer);
    end
  endtask

  task automatic send_px(input logic [15:0] px, input logic exp_v,
                         input logic [7:0] exp_a, input logic [7:0] exp_d);
    wait_rdy("send_wait");
    pix_in = px;
    send_z_buffer = 1'b1;
    tick();
    send_z_buffer = 1'b0;
    n_vec++;
    if (rdy_z_buffer !== 1'b0) begin
      n_err++; $display("FAIL rdy_in_read px=%h: got %b want 0", px, rdy_z_buffer);
    end
    tick();
    tick();
    n_vec++;
    if (upd_valid !== exp_v || upd_addr !== exp_a || upd_depth !== exp_d) begin
      n_err++;
      $display("FAIL upd px=%h: got v=%b a=%h d=%h want v=%b a=%h d=%h",
               px, upd_valid, upd_addr, upd_depth, exp_v, exp_a, exp_d);
    end
  endtask

  task automatic read_disp(input logic [7:0] a, input logic [7:0] exp_d);
    disp_addr = a;
    tick();
    n_vec++;
    if (disp_depth !== exp_d) begin
      n_err++;
      $display("FAIL disp@%h: got %h want %h", a, disp_depth, exp_d);
    end
  endtask

  // Counts cycles with rdy low after the current point; a full sweep is 256.
  task automatic check_sweep(input string name, input logic pulse_clear);
    int n;
    n = 0;
    while (!rdy_z_buffer && n < 400) begin
      clear = (pulse_clear && n == 10);
      tick();
      n++;
    end
    clear = 1'b0;
    n_vec++;
    if (n !== 256) begin
      n_err++; $display("FAIL %s: sweep cycles got %0d want 256", name, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pix_in = '0; send_z_buffer = 1'b0; clear = 1'b0; disp_addr = '0;
    tick();
    tick();
    n_vec++;
    if (rdy_z_buffer !== 1'b0 || busy_clear !== 1'b1 || upd_valid !== 1'b0 ||
        upd_addr !== 8'h00 || upd_depth !== 8'h00 || disp_depth !== 8'h00) begin
      n_err++;
      $display("FAIL reset_vals: got rdy=%b busy=%b v=%b a=%h d=%h disp=%h want 0 1 0 00 00 00",
               rdy_z_buffer, busy_clear, upd_valid, upd_addr, upd_depth, disp_depth);
    end
    reset = 1'b0;
    check_sweep("startup", 1'b0);
    read_disp(8'h10, 8'hFF);
  endtask

  task automatic test_pass_reject();
    send_px(16'h1040, 1'b1, 8'h10, 8'h40);
    send_px(16'h1050, 1'b0, 8'h10, 8'h40);
    read_disp(8'h10, 8'h40);
    send_px(16'h1040, 1'b0, 8'h10, 8'h40);
    send_px(16'h20FF, 1'b0, 8'h10, 8'h40);
    read_disp(8'h20, 8'hFF);
    send_px(16'h3000, 1'b1, 8'h30, 8'h00);
    read_disp(8'h30, 8'h00);
  endtask

  task automatic test_back_to_back();
    wait_rdy("stall_wait");
    pix_in = 16'h0301;
    send_z_buffer = 1'b1;
    tick();
    tick();
    n_vec++;
    if (rdy_z_buffer !== 1'b0 || upd_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_mid1: got rdy=%b v=%b want 0 0", rdy_z_buffer, upd_valid);
    end
    tick();
    n_vec++;
    if (upd_valid !== 1'b1 || upd_addr !== 8'h03 || upd_depth !== 8'h01 || rdy_z_buffer !== 1'b1) begin
      n_err++;
      $display("FAIL stall_px1: got v=%b a=%h d=%h rdy=%b want 1 03 01 1",
               upd_valid, upd_addr, upd_depth, rdy_z_buffer);
    end
    pix_in = 16'h0300;
    tick();
    n_vec++;
    if (upd_valid !== 1'b0 || rdy_z_buffer !== 1'b0) begin
      n_err++; $display("FAIL stall_mid2: got v=%b rdy=%b want 0 0", upd_valid, rdy_z_buffer);
    end
    tick();
    tick();
    send_z_buffer = 1'b0;
    n_vec++;
    if (upd_valid !== 1'b1 || upd_addr !== 8'h03 || upd_depth !== 8'h00) begin
      n_err++;
      $display("FAIL stall_px2: got v=%b a=%h d=%h want 1 03 00", upd_valid, upd_addr, upd_depth);
    end
    tick();
    n_vec++;
    if (upd_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_pulse: got v=%b want 0", upd_valid);
    end
    read_disp(8'h03, 8'h00);
  endtask

  task automatic test_clear_in_cmp();
    wait_rdy("clr_wait");
    pix_in = 16'h0505;
    send_z_buffer = 1'b1;
    tick();
    send_z_buffer = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_vec++;
    if (upd_valid !== 1'b1 || upd_depth !== 8'h05 || rdy_z_buffer !== 1'b0 || busy_clear !== 1'b0) begin
      n_err++;
      $display("FAIL clr_cmp: got v=%b d=%h rdy=%b busy=%b want 1 05 0 0",
               upd_valid, upd_depth, rdy_z_buffer, busy_clear);
    end
    tick();
    n_vec++;
    if (busy_clear !== 1'b1) begin
      n_err++; $display("FAIL clr_start: got busy=%b want 1", busy_clear);
    end
    // A second request mid-sweep must not extend or repeat the sweep.
    check_sweep("clr_sweep", 1'b1);
    tick();
    n_vec++;
    if (busy_clear !== 1'b0 || rdy_z_buffer !== 1'b1) begin
      n_err++; $display("FAIL clr_absorb: got busy=%b rdy=%b want 0 1", busy_clear, rdy_z_buffer);
    end
    read_disp(8'h05, 8'hFF);
    read_disp(8'h10, 8'hFF);
  endtask

  task automatic test_stats();
    send_px(16'h6010, 1'b1, 8'h60, 8'h10);
    send_px(16'h6120, 1'b1, 8'h61, 8'h20);
    send_px(16'h6010, 1'b0, 8'h61, 8'h20);
    send_px(16'h6005, 1'b1, 8'h60, 8'h05);
    send_px(16'h62FF, 1'b0, 8'h60, 8'h05);
`ifdef Z_BUFFER_STATS_EN
    n_vec++;
    if (cnt_pass !== 16'd3 || cnt_reject !== 16'd2) begin
      n_err++; $display("FAIL stats_cnt: got %0d/%0d want 3/2", cnt_pass, cnt_reject);
    end
`endif
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    check_sweep("stats_clear", 1'b0);
`ifdef Z_BUFFER_STATS_EN
    n_vec++;
    if (cnt_pass !== 16'd0 || cnt_reject !== 16'd0) begin
      n_err++; $display("FAIL stats_zero: got %0d/%0d want 0/0", cnt_pass, cnt_reject);
    end
`endif
    read_disp(8'h60, 8'hFF);
  endtask

  task automatic test_reset_mid();
    wait_rdy("rst_wait");
    pix_in = 16'h4010;
    send_z_buffer = 1'b1;
    tick();
    send_z_buffer = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if (busy_clear !== 1'b1 || upd_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_mid: got busy=%b v=%b want 1 0", busy_clear, upd_valid);
    end
    check_sweep("rst_sweep", 1'b0);
    read_disp(8'h40, 8'hFF);
  endtask

  initial begin
    test_reset();
    test_pass_reject();
    test_back_to_back();
    test_clear_in_cmp();
    test_stats();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
